// File: rtl/decode_stage.sv
// decode_stage: RV-style instruction decode with a single output pipeline
// register, valid/ready handshakes, load-use bubble insertion and flush.
// Optional feature macro: DECODE_STAGE_ILLEGAL_EN adds out_illegal and
// suppresses architectural side effects of illegal instructions.
module decode_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_MemtoReg,
    output logic            out_RegWrite,
    output logic            out_MemWrite,
    output logic            out_MemRead,
    output logic            out_Jump,
    output logic            out_JALR,
    output logic            out_Branch,
    output logic            out_ALUSrcA,
    output logic [1:0]      out_ALUSrcB,
    output logic [3:0]      out_ALUCode,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_Imm,
    output logic [XLEN-1:0] out_offset,
    output logic [15:0]     stall_cnt
`ifdef DECODE_STAGE_ILLEGAL_EN
    ,
    output logic            out_illegal
`endif
);

    localparam int unsigned CNT_W = 16;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_SB    = 7'b1100011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_LUI  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    typedef enum logic {RUN, STALL} state_t;

    state_t state_q, state_d;

    logic [6:0] op;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;
    logic is_r, is_i, is_sb, is_lw, is_jalr, is_sw, is_lui, is_auipc, is_jal;
    logic uses_rs1, uses_rs2;
    logic stall, accept;

    logic            d_memtoreg, d_regwrite, d_memwrite, d_memread;
    logic            d_jump, d_jalr, d_branch, d_alusrca;
    logic [1:0]      d_alusrcb;
    logic [3:0]      d_alucode;
    logic [XLEN-1:0] d_imm, d_offset;
    logic            d_illegal;

    assign op  = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign rd  = in_instr[11:7];
    assign rs1 = in_instr[19:15];
    assign rs2 = in_instr[24:20];

    assign is_r     = (op == OP_R);
    assign is_i     = (op == OP_I);
    assign is_sb    = (op == OP_SB);
    assign is_lw    = (op == OP_LW);
    assign is_jalr  = (op == OP_JALR);
    assign is_sw    = (op == OP_SW);
    assign is_lui   = (op == OP_LUI);
    assign is_auipc = (op == OP_AUIPC);
    assign is_jal   = (op == OP_JAL);

    assign uses_rs1 = ~(is_lui | is_auipc | is_jal);
    assign uses_rs2 = is_r | is_sb | is_sw;

    // Illegal detection: unknown opcode, or R-type with an unsupported funct7
    always_comb begin
        d_illegal = ~(is_r | is_i | is_sb | is_lw | is_jalr | is_sw | is_lui | is_auipc | is_jal);
        if (is_r && (in_instr[31:25] != 7'b0000000) && (in_instr[31:25] != 7'b0100000)) begin
            d_illegal = 1'b1;
        end
    end

    // Control-signal decode of the incoming instruction
    always_comb begin
        d_memread  = is_lw;
        d_memtoreg = is_lw;
        d_memwrite = is_sw;
        d_branch   = is_sb;
        d_jump     = is_jal | is_jalr;
        d_jalr     = is_jalr;
        d_regwrite = is_r | is_i | is_lw | is_jalr | is_lui | is_auipc | is_jal;
        d_alusrca  = is_jal | is_jalr | is_auipc;
        d_alusrcb  = {is_jal | is_jalr, ~(is_r | is_jal | is_jalr | is_sb)};
`ifdef DECODE_STAGE_ILLEGAL_EN
        if (d_illegal) begin
            d_regwrite = 1'b0;
            d_memwrite = 1'b0;
            d_jump     = 1'b0;
            d_branch   = 1'b0;
        end
`endif
    end

    // ALU operation select; funct3 table shared by R and I, bit30 picks sub/sra
    always_comb begin
        d_alucode = ALU_ADD;
        if (is_r || is_i) begin
            case (f3)
                3'd0:    d_alucode = (is_r && in_instr[30]) ? ALU_SUB : ALU_ADD;
                3'd1:    d_alucode = ALU_SLL;
                3'd2:    d_alucode = ALU_SLT;
                3'd3:    d_alucode = ALU_SLTU;
                3'd4:    d_alucode = ALU_XOR;
                3'd5:    d_alucode = in_instr[30] ? ALU_SRA : ALU_SRL;
                3'd6:    d_alucode = ALU_OR;
                default: d_alucode = ALU_AND;
            endcase
        end else if (is_lui) begin
            d_alucode = ALU_LUI;
        end else if (is_sb) begin
            d_alucode = ALU_SUB;
        end
    end

    // Immediate and branch/jump offset generation
    always_comb begin
        d_imm    = '0;
        d_offset = '0;
        if (is_i && (f3 == 3'd1 || f3 == 3'd5)) begin
            d_imm = XLEN'(in_instr[20 +: SHAMT_W]);
        end else if (is_i || is_lw || is_jalr) begin
            d_imm = XLEN'($signed(in_instr[31:20]));
        end else if (is_sw) begin
            d_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
        end else if (is_lui || is_auipc) begin
            d_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
        end
        if (is_jalr) begin
            d_offset = XLEN'($signed(in_instr[31:20]));
        end else if (is_jal) begin
            d_offset = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                      in_instr[30:21], 1'b0}));
        end else if (is_sb) begin
            d_offset = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                      in_instr[11:8], 1'b0}));
        end
    end

    // Load-use hazard: registered LW leaving now, incoming consumer of its rd
    always_comb begin
        stall = (state_q == RUN) && out_valid && out_ready && out_MemRead &&
                (out_rd != 5'd0) && in_valid &&
                ((uses_rs1 && (rs1 == out_rd)) || (uses_rs2 && (rs2 == out_rd)));
        in_ready = rst_n & ~stall & (~out_valid | out_ready);
        accept   = in_valid & in_ready;
    end

    // Next-state logic: one-cycle STALL per hazard; flush forces RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (stall) state_d = STALL;
            STALL:   state_d = RUN;
            default: state_d = RUN;
        endcase
        if (flush) state_d = RUN;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Pipeline register and stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rd       <= '0;
            out_MemtoReg <= 1'b0;
            out_RegWrite <= 1'b0;
            out_MemWrite <= 1'b0;
            out_MemRead  <= 1'b0;
            out_Jump     <= 1'b0;
            out_JALR     <= 1'b0;
            out_Branch   <= 1'b0;
            out_ALUSrcA  <= 1'b0;
            out_ALUSrcB  <= '0;
            out_ALUCode  <= '0;
            out_funct3   <= '0;
            out_Imm      <= '0;
            out_offset   <= '0;
            stall_cnt    <= '0;
`ifdef DECODE_STAGE_ILLEGAL_EN
            out_illegal  <= 1'b0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                out_valid    <= 1'b1;
                out_pc       <= in_pc;
                out_rs1      <= rs1;
                out_rs2      <= rs2;
                out_rd       <= rd;
                out_MemtoReg <= d_memtoreg;
                out_RegWrite <= d_regwrite;
                out_MemWrite <= d_memwrite;
                out_MemRead  <= d_memread;
                out_Jump     <= d_jump;
                out_JALR     <= d_jalr;
                out_Branch   <= d_branch;
                out_ALUSrcA  <= d_alusrca;
                out_ALUSrcB  <= d_alusrcb;
                out_ALUCode  <= d_alucode;
                out_funct3   <= f3;
                out_Imm      <= d_imm;
                out_offset   <= d_offset;
`ifdef DECODE_STAGE_ILLEGAL_EN
                out_illegal  <= d_illegal;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (XLEN=64): directed scenarios plus
// randomized traffic compared cycle by cycle against a transaction model.
module tb_decode_stage;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned SHAMT_W = 6;

    logic            clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc, out_pc, out_Imm, out_offset;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic            out_MemtoReg, out_RegWrite, out_MemWrite, out_MemRead;
    logic            out_Jump, out_JALR, out_Branch, out_ALUSrcA;
    logic [1:0]      out_ALUSrcB;
    logic [3:0]      out_ALUCode;
    logic [2:0]      out_funct3;
    logic [15:0]     stall_cnt;
`ifdef DECODE_STAGE_ILLEGAL_EN
    logic            out_illegal;
`endif

    int checks = 0;
    int errors = 0;

    decode_stage #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_MemtoReg(out_MemtoReg), .out_RegWrite(out_RegWrite),
        .out_MemWrite(out_MemWrite), .out_MemRead(out_MemRead),
        .out_Jump(out_Jump), .out_JALR(out_JALR), .out_Branch(out_Branch),
        .out_ALUSrcA(out_ALUSrcA), .out_ALUSrcB(out_ALUSrcB),
        .out_ALUCode(out_ALUCode), .out_funct3(out_funct3),
        .out_Imm(out_Imm), .out_offset(out_offset), .stall_cnt(stall_cnt)
`ifdef DECODE_STAGE_ILLEGAL_EN
        , .out_illegal(out_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1, rs2, rd;
        logic            memtoreg, regwrite, memwrite, memread;
        logic            jump, jalr, branch, alusrca;
        logic [1:0]      alusrcb;
        logic [3:0]      alucode;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm, offset;
        logic            illegal;
    } dec_t;

    // Model state: what the output register should hold
    dec_t        m_out;
    logic        m_valid, m_stalled;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Interpret the low 'bits' of v as a two's-complement number
    function automatic logic [63:0] sx(input logic [31:0] v, input int bits);
        longint m, x;
        m = longint'(1) << bits;
        x = longint'({32'd0, v}) & (m - 1);
        if (x >= (m >>> 1)) x = x - m;
        return 64'(x);
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        dec_t d;
        logic [6:0] op;
        logic [2:0] f3;
        bit r, i, sb, lw, jr, sw, lui, aui, jal, bad;
        d   = '0;
        op  = ins[6:0];
        f3  = ins[14:12];
        r   = (op == 7'h33); i   = (op == 7'h13); sb  = (op == 7'h63);
        lw  = (op == 7'h03); jr  = (op == 7'h67); sw  = (op == 7'h23);
        lui = (op == 7'h37); aui = (op == 7'h17); jal = (op == 7'h6F);
        d.pc = pc; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7]; d.funct3 = f3;
        d.memread = lw; d.memtoreg = lw; d.memwrite = sw; d.branch = sb;
        d.jump = jal | jr; d.jalr = jr; d.alusrca = jal | jr | aui;
        d.regwrite = r | i | lw | jr | lui | aui | jal;
        if (jal || jr)     d.alusrcb = 2'd2;
        else if (r || sb)  d.alusrcb = 2'd0;
        else               d.alusrcb = 2'd1;
        if (r || i) begin
            case (f3)
                3'd0: d.alucode = (r && ins[30]) ? 4'd1 : 4'd0;
                3'd1: d.alucode = 4'd6;
                3'd2: d.alucode = 4'd9;
                3'd3: d.alucode = 4'd10;
                3'd4: d.alucode = 4'd4;
                3'd5: d.alucode = ins[30] ? 4'd8 : 4'd7;
                3'd6: d.alucode = 4'd5;
                default: d.alucode = 4'd3;
            endcase
        end else if (lui) d.alucode = 4'd2;
        else if (sb)      d.alucode = 4'd1;
        if (i && (f3 == 3'd1 || f3 == 3'd5)) d.imm = 64'((ins >> 20) & 32'h3F);
        else if (i || lw || jr)              d.imm = sx(ins >> 20, 12);
        else if (sw)                         d.imm = sx(((ins >> 25) << 5) | ((ins >> 7) & 32'h1F), 12);
        else if (lui || aui)                 d.imm = sx(ins & 32'hFFFF_F000, 32);
        if (jr)       d.offset = sx(ins >> 20, 12);
        else if (jal) d.offset = sx((((ins >> 31) & 32'h1) << 20) | (((ins >> 12) & 32'hFF) << 12) |
                                    (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1), 21);
        else if (sb)  d.offset = sx((((ins >> 31) & 32'h1) << 12) | (((ins >> 7) & 32'h1) << 11) |
                                    (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1), 13);
        bad = !(r | i | sb | lw | jr | sw | lui | aui | jal) ||
              (r && ins[31:25] != 7'h00 && ins[31:25] != 7'h20);
`ifdef DECODE_STAGE_ILLEGAL_EN
        d.illegal = bad;
        if (bad) begin
            d.regwrite = 1'b0; d.memwrite = 1'b0; d.jump = 1'b0; d.branch = 1'b0;
        end
`else
        d.illegal = 1'b0;
        if (bad) d.illegal = 1'b0;
`endif
        return d;
    endfunction

    // One clock: compare DUT to model at negedge, advance model at posedge
    task automatic tick();
        dec_t in_d;
        logic hz, rdy, n_valid, n_stalled;
        logic [15:0] n_cnt;
        dec_t n_out;
        @(negedge clk);
        in_d = ref_decode(in_instr, in_pc);
        hz = rst_n && !m_stalled && m_valid && out_ready && m_out.memread && m_out.rd != 5'd0 &&
             in_valid && ((!(in_instr[6:0] inside {7'h37, 7'h17, 7'h6F}) && in_d.rs1 == m_out.rd) ||
                          ((in_instr[6:0] inside {7'h33, 7'h63, 7'h23}) && in_d.rs2 == m_out.rd));
        rdy = rst_n && !hz && (!m_valid || out_ready);
        check("in_ready",  64'(in_ready),  64'(rdy));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        check("pc",        64'(out_pc),    64'(m_out.pc));
        check("rs1",       64'(out_rs1),   64'(m_out.rs1));
        check("rs2",       64'(out_rs2),   64'(m_out.rs2));
        check("rd",        64'(out_rd),    64'(m_out.rd));
        check("ctl", 64'({out_MemtoReg, out_RegWrite, out_MemWrite, out_MemRead,
                          out_Jump, out_JALR, out_Branch, out_ALUSrcA}),
                     64'({m_out.memtoreg, m_out.regwrite, m_out.memwrite, m_out.memread,
                          m_out.jump, m_out.jalr, m_out.branch, m_out.alusrca}));
        check("alusrcb",   64'(out_ALUSrcB), 64'(m_out.alusrcb));
        check("alucode",   64'(out_ALUCode), 64'(m_out.alucode));
        check("funct3",    64'(out_funct3),  64'(m_out.funct3));
        check("imm",       64'(out_Imm),     64'(m_out.imm));
        check("offset",    64'(out_offset),  64'(m_out.offset));
`ifdef DECODE_STAGE_ILLEGAL_EN
        check("illegal",   64'(out_illegal), 64'(m_out.illegal));
`endif
        n_out = m_out; n_valid = m_valid; n_cnt = m_cnt; n_stalled = 1'b0;
        if (!rst_n) begin
            n_out = '0; n_valid = 1'b0; n_cnt = 16'd0;
        end else if (flush) begin
            n_valid = 1'b0;
        end else begin
            if (in_valid && rdy) begin
                n_out = in_d; n_valid = 1'b1;
            end else if (out_ready) begin
                n_valid = 1'b0;
            end
            if (hz && m_cnt != 16'hFFFF) n_cnt = m_cnt + 16'd1;
            n_stalled = hz;
        end
        @(posedge clk);
        m_out = n_out; m_valid = n_valid; m_cnt = n_cnt; m_stalled = n_stalled;
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc);
        in_valid = v; in_instr = ins; in_pc = pc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  op;
        case ($urandom_range(0, 9))
            0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h63; 3: op = 7'h03; 4: op = 7'h67;
            5: op = 7'h23; 6: op = 7'h37; 7: op = 7'h17; 8: op = 7'h6F;
            default: op = 7'($urandom);
        endcase
        ins = $urandom;
        ins[6:0]   = op;
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        if (op == 7'h33 && $urandom_range(0, 3) != 0) ins[31:25] = ins[30] ? 7'h20 : 7'h00;
        return ins;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, '0);
        m_out = '0; m_valid = 1'b0; m_cnt = 16'd0; m_stalled = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tick();                                   // reset state checked here
        rst_n = 1'b1;

        // add x3,x1,x2
        drive(1'b1, 32'h002081B3, 64'h100);
        tick();
        drive(1'b0, 32'h0, '0);
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_alu",   64'(out_ALUCode), 64'd0);
        check("add_rw",    64'(out_RegWrite), 64'd1);
        check("add_rd",    64'(out_rd), 64'd3);
        check("add_srcb",  64'(out_ALUSrcB), 64'd0);
        tick();

        // lw x5,8(x1) then add x6,x5,x0 back to back
        drive(1'b1, 32'h0080A283, 64'h200);
        tick();
        drive(1'b1, 32'h00028333, 64'h204);
        #1;
        check("lu_ready0", 64'(in_ready), 64'd0);
        tick();
        check("lu_bubble", 64'(out_valid), 64'd0);
        check("lu_cnt",    64'(stall_cnt), 64'd1);
        check("lu_ready1", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, 32'h0, '0);
        check("lu_add_rd", 64'(out_rd), 64'd6);
        tick();

        // jal x1,-4
        drive(1'b1, 32'hFFDFF0EF, 64'h300);
        tick();
        drive(1'b0, 32'h0, '0);
        check("jal_off",  out_offset, 64'hFFFF_FFFF_FFFF_FFFC);
        check("jal_jump", 64'(out_Jump), 64'd1);
        check("jal_srcb", 64'(out_ALUSrcB), 64'd2);
        tick();

        // srai x1,x1,3 held under backpressure
        drive(1'b1, 32'h4030D093, 64'h400);
        tick();
        drive(1'b1, 32'h002081B3, 64'h404);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("srai_ready", 64'(in_ready), 64'd0);
            check("srai_alu",   64'(out_ALUCode), 64'd8);
            check("srai_imm",   out_Imm, 64'd3);
            check("srai_pc",    out_pc, 64'h400);
            tick();
        end
        out_ready = 1'b1;
        tick();
        drive(1'b0, 32'h0, '0);
        tick();

        // flush together with a load-use hazard and an input offer
        drive(1'b1, 32'h0080A283, 64'h500);
        tick();
        drive(1'b1, 32'h00028333, 64'h504);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, '0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_cnt",   64'(stall_cnt), 64'd1);
        tick();

        // reset while a held instruction is valid
        drive(1'b1, 32'h002081B3, 64'h600);
        tick();
        drive(1'b0, 32'h0, '0);
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_cnt",   64'(stall_cnt), 64'd0);
        rst_n = 1'b1; out_ready = 1'b1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 9) < 7, rand_instr(), {32'($urandom), 32'($urandom)});
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
